id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file.
- Captures the two register read operands, immediate, register indices and decoded control bits on each rising clock edge.
- Detects load-use hazards: stalls the front end and inserts a bubble.
- Applies EX/MEM and MEM/WB forwarding, so the ALU receives correct operands.

Parameters:
- DW, 32, datapath width.
- AW, 5, register index width.
- CW, 9, control bundle width {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[2:0]}.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt, id_rd  in  AW each  register indices from decode.
- id_rd1, id_rd2  in  DW each  register file ReadData1/ReadData2.
- id_imm  in  DW  sign-extended immediate.
- id_ctrl  in  CW  decoded control bundle.
- flush  in  1  branch/jump redirect; kill the decode slot.
- mem_regwrite  in  1, mem_rd  in  AW, mem_result  in  DW: EX/MEM write-back info.
- wb_regwrite  in  1, wb_rd  in  AW, wb_result  in  DW: MEM/WB write-back info.
- stall  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  EX slot valid.
- ex_ctrl  out  CW  registered control bundle.
- ex_op_a  out  DW  forwarded ALU operand A.
- ex_op_b  out  DW  ALU operand B after forwarding and ALUSrc mux.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_dest  out  AW  destination index (rd if RegDst, else rt).

Behaviour:
- Reset (rst=0, async): all registered state cleared: ex_valid=0, ex_ctrl=0, captured data/indices/imm=0, so ex_dest=0 and stall=0.
- Register file writes on the falling edge, so a WB write lands before the ID capture on the next rising edge. No ID-side bypass is needed here.
- Load-use detection (combinational):
  - stall = ex_valid & ex_ctrl.MemRead & ex_dest≠0 & id_valid & (ex_dest==id_rs | (ex_dest==id_rt & id_ctrl uses rt as source)).
  - rt is a source unless ALUSrc=1 and MemWrite=0.
- Rising edge, priority order:
  1. flush=1: load bubble (ex_valid=0, ex_ctrl=0). Flush overrides stall.
  2. Else stall=1: load bubble. The instruction remains in ID and is re-presented next cycle.
  3. Else: capture all id_* inputs; ex_valid=id_valid; ex_ctrl=id_valid ? id_ctrl : 0.
- Latency: exactly one cycle ID→EX. A load-use hazard costs exactly one bubble, because the second cycle sees ex_valid=0 and stall drops.
- Forwarding for captured rs and rt, combinational on registered state. Each source selects independently:
  - MEM hit (mem_regwrite & mem_rd≠0 & mem_rd==idx) → mem_result.
  - Else WB hit (same conditions with wb_*) → wb_result.
  - Else captured register value.
  - MEM has priority over WB when both match.
- Index 0 is never forwarded, so R0 reads stay 0.
- ex_op_b = ALUSrc ? ex_imm : forwarded rt. ex_store_data is always the forwarded rt.
- Bubble slots: ex_ctrl=0 guarantees no RegWrite/MemRead/MemWrite downstream. Data fields in a bubble are don't-care but deterministic: they are held at their prior values.
- Asserting reset mid-stall clears stall within the same delta, because ex_valid=0.

Decomposition:
- Shared package holds:
  - control bundle field offsets (CTRL_REGWRITE … CTRL_ALUOP_LSB);
  - CW/AW/DW constants;
  - ALUOp encodings.
- One sub-module, forward_sel: inputs src index, captured value, mem/wb triples; output forwarded value. It is instantiated twice (rs, rt).
- Hazard detection stays inline in id_ex_stage.

Test Plan:
- Reset: hold rst=0 with id inputs active, then release → ex_valid=0, ex_ctrl=0, stall=0 until the first posedge after release.
- Plain pass-through: id_rd1=0x11, id_rd2=0x22, ALUSrc=0, RegDst=1, rd=5 → next cycle ex_op_a=0x11, ex_op_b=0x22, ex_dest=5.
- Load-use: EX holds lw with rt=8; ID has add rs=8 →
  - stall=1 for exactly one cycle, followed by a bubble (ex_valid=0);
  - the add then enters EX with op_a=wb_result when wb_rd=8, wb_result=0xDEAD.
- Forward priority: captured rs=3 with mem_rd=3/mem_result=0xAAAA and wb_rd=3/wb_result=0xBBBB, both regwrite=1 → ex_op_a=0xAAAA. Same case with mem_regwrite=0 → 0xBBBB.
- R0 guard: rs=0, mem_rd=0, mem_regwrite=1, mem_result=0xFFFF, id_rd1=0 → ex_op_a=0.
- Flush during stall: stall condition and flush=1 together → bubble, ex_ctrl=0. Next cycle with flush=0 and a hazard-free instruction → it captures normally.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: widths, control-bundle field offsets, ALUOp codes.
package id_ex_stage_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 9;

    // Control bundle layout: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[2:0]}
    localparam int CTRL_REGWRITE  = 8;
    localparam int CTRL_MEMREAD   = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGDST    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_RTYPE = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4,
        ALUOP_SLT   = 3'd5,
        ALUOP_LUI   = 3'd6,
        ALUOP_XOR   = 3'd7
    } aluop_e;

endpackage

// File: rtl/id_ex_stage_forward_sel.sv
// Per-source forwarding mux: EX/MEM result beats MEM/WB result beats the captured value.
module forward_sel
    import id_ex_stage_pkg::*;
#(
    parameter int DW = id_ex_stage_pkg::DW,
    parameter int AW = id_ex_stage_pkg::AW
) (
    input  logic [AW-1:0] i_idx,
    input  logic [DW-1:0] i_val,
    input  logic          i_mem_regwrite,
    input  logic [AW-1:0] i_mem_rd,
    input  logic [DW-1:0] i_mem_result,
    input  logic          i_wb_regwrite,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [DW-1:0] i_wb_result,
    output logic [DW-1:0] o_val
);

    logic w_mem_hit;
    logic w_wb_hit;

    // R0 is hardwired; a write "to" it must never leak back into an operand.
    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_idx);
    assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_idx);

    always_comb begin
        o_val = i_val;
        if (w_mem_hit)
            o_val = i_mem_result;
        else if (w_wb_hit)
            o_val = i_wb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and EX operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = id_ex_stage_pkg::DW,
    parameter int AW = id_ex_stage_pkg::AW,
    parameter int CW = id_ex_stage_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [CW-1:0] id_ctrl,
    input  logic          flush,
    input  logic          mem_regwrite,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic          stall,
    output logic          ex_valid,
    output logic [CW-1:0] ex_ctrl,
    output logic [DW-1:0] ex_op_a,
    output logic [DW-1:0] ex_op_b,
    output logic [DW-1:0] ex_store_data,
    output logic [AW-1:0] ex_dest
);

    logic          r_valid;
    logic [CW-1:0] r_ctrl;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;

    logic [AW-1:0] w_dest;
    logic          w_id_rt_src;
    logic          w_stall;
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    assign w_dest = r_ctrl[CTRL_REGDST] ? r_rd : r_rt;

    // Immediate-ALU ops ignore rt, but stores read it as data even with ALUSrc set.
    assign w_id_rt_src = !(id_ctrl[CTRL_ALUSRC] && !id_ctrl[CTRL_MEMWRITE]);

    assign w_stall = r_valid && r_ctrl[CTRL_MEMREAD] && (w_dest != '0) && id_valid &&
                     ((w_dest == id_rs) || ((w_dest == id_rt) && w_id_rt_src));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (flush || w_stall) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    // Data fields hold through bubbles so the EX datapath stays deterministic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs  <= '0;
            r_rt  <= '0;
            r_rd  <= '0;
            r_rd1 <= '0;
            r_rd2 <= '0;
            r_imm <= '0;
        end else if (!(flush || w_stall)) begin
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;
            r_rd1 <= id_rd1;
            r_rd2 <= id_rd2;
            r_imm <= id_imm;
        end
    end

    forward_sel #(.DW(DW), .AW(AW)) u_fwd_rs (
        .i_idx          (r_rs),
        .i_val          (r_rd1),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_rd       (mem_rd),
        .i_mem_result   (mem_result),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_result    (wb_result),
        .o_val          (w_fwd_a)
    );

    forward_sel #(.DW(DW), .AW(AW)) u_fwd_rt (
        .i_idx          (r_rt),
        .i_val          (r_rd2),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_rd       (mem_rd),
        .i_mem_result   (mem_result),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_result    (wb_result),
        .o_val          (w_fwd_b)
    );

    assign stall         = w_stall;
    assign ex_valid      = r_valid;
    assign ex_ctrl       = r_ctrl;
    assign ex_dest       = w_dest;
    assign ex_op_a       = w_fwd_a;
    assign ex_op_b       = r_ctrl[CTRL_ALUSRC] ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, pass-through, load-use, forwarding, R0, flush.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 9;

    // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[2:0]}
    localparam logic [CW-1:0] C_RTYPE = 9'b1_0_0_0_0_1_010;
    localparam logic [CW-1:0] C_LW    = 9'b1_1_0_1_1_0_000;
    localparam logic [CW-1:0] C_SW    = 9'b0_0_1_0_1_0_000;
    localparam logic [CW-1:0] C_ADDI  = 9'b1_0_0_0_1_0_000;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          flush;
    logic          mem_regwrite;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_regwrite;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_result;
    logic          stall;
    logic          ex_valid;
    logic [CW-1:0] ex_ctrl;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_store_data;
    logic [AW-1:0] ex_dest;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .flush         (flush),
        .mem_regwrite  (mem_regwrite),
        .mem_rd        (mem_rd),
        .mem_result    (mem_result),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_ctrl       (ex_ctrl),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          input logic [DW-1:0] imm, input logic [CW-1:0] c);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_rd1   = d1;
        id_rd2   = d2;
        id_imm   = imm;
        id_ctrl  = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        mem_regwrite = 1'b0;
        mem_rd       = '0;
        mem_result   = '0;
        wb_regwrite  = 1'b0;
        wb_rd        = '0;
        wb_result    = '0;
        // Pass-through vector is already active while reset is held
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h100, C_RTYPE);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_ctrl",  {23'b0, ex_ctrl},  32'h0);
        chk("rst_stall", {31'b0, stall},    32'h0);
        chk("rst_dest",  {27'b0, ex_dest},  32'h0);
        rst = 1'b1;
        #2;
        chk("rel_valid", {31'b0, ex_valid}, 32'h0);
        chk("rel_ctrl",  {23'b0, ex_ctrl},  32'h0);

        // Plain pass-through
        step();
        chk("pt_valid", {31'b0, ex_valid}, 32'h1);
        chk("pt_ctrl",  {23'b0, ex_ctrl},  {23'b0, C_RTYPE});
        chk("pt_op_a",  ex_op_a,           32'h11);
        chk("pt_op_b",  ex_op_b,           32'h22);
        chk("pt_sdata", ex_store_data,     32'h22);
        chk("pt_dest",  {27'b0, ex_dest},  32'h5);

        // Immediate path: op_b from imm, dest from rt, store data still rt value
        set_id(1'b1, 5'd1, 5'd6, 5'd7, 32'h11, 32'h66, 32'h40, C_ADDI);
        step();
        chk("imm_op_b",  ex_op_b,          32'h40);
        chk("imm_sdata", ex_store_data,    32'h66);
        chk("imm_dest",  {27'b0, ex_dest}, 32'h6);

        // Invalid slot captured -> EX invalid, ctrl zero
        set_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, C_RTYPE);
        step();
        chk("inv_valid", {31'b0, ex_valid}, 32'h0);
        chk("inv_ctrl",  {23'b0, ex_ctrl},  32'h0);

        // Load-use: lw r8 in EX, add with rs=8 in ID
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW);
        step();
        chk("lw_dest", {27'b0, ex_dest}, 32'h8);
        set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h1234, 32'h22, 32'h0, C_RTYPE);
        #1;
        chk("lu_stall", {31'b0, stall}, 32'h1);
        step();
        chk("lu_bub_valid", {31'b0, ex_valid}, 32'h0);
        chk("lu_bub_ctrl",  {23'b0, ex_ctrl},  32'h0);
        chk("lu_stall_drop", {31'b0, stall},   32'h0);
        wb_regwrite = 1'b1;
        wb_rd       = 5'd8;
        wb_result   = 32'hDEAD;
        step();
        chk("lu_valid", {31'b0, ex_valid}, 32'h1);
        chk("lu_op_a",  ex_op_a,           32'hDEAD);
        chk("lu_op_b",  ex_op_b,           32'h22);
        chk("lu_dest",  {27'b0, ex_dest},  32'h9);
        chk("lu_nostall", {31'b0, stall},  32'h0);
        wb_regwrite = 1'b0;

        // rt-source qualification against a load in EX
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW);
        step();
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h4, C_ADDI);
        #1;
        chk("addi_rt_nostall", {31'b0, stall}, 32'h0);
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h4, C_SW);
        #1;
        chk("sw_rt_stall", {31'b0, stall}, 32'h1);
        set_id(1'b1, 5'd3, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, C_RTYPE);
        #1;
        chk("r_rt_stall", {31'b0, stall}, 32'h1);
        set_id(1'b0, 5'd8, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, C_RTYPE);
        #1;
        chk("inv_nostall", {31'b0, stall}, 32'h0);

        // Reset asserted mid-stall clears stall immediately
        set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, C_RTYPE);
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        rst = 1'b1;

        // Load to r0 never stalls
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, C_LW);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, C_RTYPE);
        #1;
        chk("lw_r0_nostall", {31'b0, stall}, 32'h0);

        // Forward priority on captured rs=3, rt=4
        set_id(1'b1, 5'd3, 5'd4, 5'd7, 32'h3333, 32'h4444, 32'h0, C_RTYPE);
        step();
        mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'hAAAA;
        wb_regwrite  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'hBBBB;
        #1;
        chk("fw_mem_pri", ex_op_a, 32'hAAAA);
        chk("fw_b_none",  ex_op_b, 32'h4444);
        mem_regwrite = 1'b0;
        #1;
        chk("fw_wb", ex_op_a, 32'hBBBB);
        wb_regwrite = 1'b0;
        #1;
        chk("fw_none", ex_op_a, 32'h3333);
        mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'hC0DE;
        #1;
        chk("fw_rt_op_b",  ex_op_b,       32'hC0DE);
        chk("fw_rt_sdata", ex_store_data, 32'hC0DE);
        chk("fw_rt_op_a",  ex_op_a,       32'h3333);
        mem_regwrite = 1'b0;

        // R0 guard
        set_id(1'b1, 5'd0, 5'd2, 5'd7, 32'h0, 32'h22, 32'h0, C_RTYPE);
        step();
        mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF;
        wb_regwrite  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'hEEEE;
        #1;
        chk("r0_guard", ex_op_a, 32'h0);
        mem_regwrite = 1'b0;
        wb_regwrite  = 1'b0;

        // Flush during stall: bubble, data held, then hazard-free capture
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, C_LW);
        step();
        set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h1234, 32'h22, 32'h0, C_RTYPE);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'b0, stall}, 32'h1);
        step();
        chk("fl_valid", {31'b0, ex_valid}, 32'h0);
        chk("fl_ctrl",  {23'b0, ex_ctrl},  32'h0);
        chk("fl_held_dest", {27'b0, ex_dest}, 32'h8);
        flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 32'h55, 32'h66, 32'h0, C_RTYPE);
        #1;
        chk("fl_nostall", {31'b0, stall}, 32'h0);
        step();
        chk("fl_cap_valid", {31'b0, ex_valid}, 32'h1);
        chk("fl_cap_op_a",  ex_op_a,           32'h55);
        chk("fl_cap_op_b",  ex_op_b,           32'h66);
        chk("fl_cap_dest",  {27'b0, ex_dest},  32'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
